// File: rtl/srl_operand_ser_if.sv
// Purpose: operand-in / bit-stream-out bundle for srl_operand_ser.
// Signals:
//   a_in, b_in  W-bit operand pair, sampled on accept
//   in_valid    operand pair is valid
//   in_ready    serializer can take a pair this cycle
//   x, y        current bit of A / B, LSB first
//   bit_valid   x/y carry a live bit
//   first_bit   bit 0 of a word
//   last_bit    bit W-1 of a word
// Modports: master = operand source / bit consumer, slave = serializer.
interface srl_operand_ser_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         in_valid;
    logic         in_ready;
    logic         x;
    logic         y;
    logic         bit_valid;
    logic         first_bit;
    logic         last_bit;

    modport master (
        output a_in, b_in, in_valid,
        input  in_ready, x, y, bit_valid, first_bit, last_bit
    );

    modport slave (
        input  a_in, b_in, in_valid,
        output in_ready, x, y, bit_valid, first_bit, last_bit
    );
endinterface

// File: rtl/srl_operand_ser.sv
// Purpose: feeder for the bit-serial adder. Accepts a W-bit operand pair over
// valid/ready and emits it LSB first, one bit pair per clock, flagging the
// first and last bit of each word. Back-to-back words stream without a bubble.
// Ports:
//   clk    system clock
//   rst_b  synchronous reset, active low
//   bus    srl_operand_ser_if.slave (operand handshake + serial bit stream)
module srl_operand_ser #(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    srl_operand_ser_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_last;
    logic             accept;

    // State and shift registers
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, handshake and output decode; x/y come only from registers
    always_comb begin
        state_d       = state_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        cnt_d         = cnt_q;
        bus.x         = 1'b0;
        bus.y         = 1'b0;
        bus.bit_valid = 1'b0;
        bus.first_bit = 1'b0;
        bus.last_bit  = 1'b0;

        at_last      = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        // Ready on the last bit lets the next word follow with no gap
        bus.in_ready = (state_q == IDLE) || at_last;
        accept       = bus.in_valid && bus.in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_sh_d  = bus.a_in;
                    b_sh_d  = bus.b_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bus.x         = a_sh_q[0];
                bus.y         = b_sh_q[0];
                bus.bit_valid = 1'b1;
                bus.first_bit = (cnt_q == '0);
                bus.last_bit  = at_last;
                if (!at_last) begin
                    a_sh_d = a_sh_q >> 1;
                    b_sh_d = b_sh_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (accept) begin
                    a_sh_d = bus.a_in;
                    b_sh_d = bus.b_in;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_srl_operand_ser.sv
// Purpose: scoreboard bench for srl_operand_ser. Stimulus pushes the expected
// bit stream of each accepted word; a monitor pops and compares whenever
// bit_valid is high. A W=4 instance feeds a small serial adder model.
// Ports: none (top-level bench).
module tb_srl_operand_ser;
    logic clk;
    logic rst_b;

    typedef struct packed {
        logic x;
        logic y;
        logic f;
        logic l;
    } bit_t;

    bit_t       exp_q[$];
    logic [4:0] res4_q[$];
    int         checks;
    int         errors;
    int         run_len;
    int         last_run;
    logic       carry4;
    logic [3:0] acc4;

    srl_operand_ser_if #(.W(8)) ifc8 ();
    srl_operand_ser_if #(.W(4)) ifc4 ();

    srl_operand_ser #(.W(8)) u_dut8 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (ifc8)
    );

    srl_operand_ser #(.W(4)) u_dut4 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (ifc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Monitor: compare every live bit against the scoreboard, idle outputs against 0
    always @(negedge clk) begin
        bit_t e;
        if (ifc8.bit_valid === 1'b1) begin
            run_len++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit: got x=%b y=%b f=%b l=%b, required no bit",
                         ifc8.x, ifc8.y, ifc8.first_bit, ifc8.last_bit);
            end else begin
                e = exp_q.pop_front();
                chk("bit_stream", 32'({ifc8.x, ifc8.y, ifc8.first_bit, ifc8.last_bit}), 32'(e));
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            chk("idle_outs", 32'({ifc8.bit_valid, ifc8.x, ifc8.y, ifc8.first_bit, ifc8.last_bit}), 32'(0));
        end
    end

    // Serial adder model on the W=4 stream; carry cleared on first_bit
    always @(negedge clk) begin
        logic cin, s, cout;
        if (ifc4.bit_valid === 1'b1) begin
            cin    = ifc4.first_bit ? 1'b0 : carry4;
            s      = ifc4.x ^ ifc4.y ^ cin;
            cout   = (ifc4.x & ifc4.y) | (ifc4.x & cin) | (ifc4.y & cin);
            acc4   = {s, acc4[3:1]};
            carry4 = cout;
            if (ifc4.last_bit) res4_q.push_back({cout, acc4});
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        ifc8.a_in     = a;
        ifc8.b_in     = b;
        ifc8.in_valid = 1'b1;
        @(negedge clk);
        while (ifc8.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ifc8.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout8: got in_ready=%b, required 1", ifc8.in_ready);
            ifc8.in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{x: a[i], y: b[i], f: (i == 0), l: (i == 7)});
        @(posedge clk);
        #1;
        ifc8.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        ifc4.a_in     = a;
        ifc4.b_in     = b;
        ifc4.in_valid = 1'b1;
        @(negedge clk);
        while (ifc4.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ifc4.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout4: got in_ready=%b, required 1", ifc4.in_ready);
            ifc4.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ifc4.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        run_len       = 0;
        last_run      = 0;
        carry4        = 1'b0;
        acc4          = '0;
        rst_b         = 1'b0;
        ifc8.a_in     = '0;
        ifc8.b_in     = '0;
        ifc8.in_valid = 1'b0;
        ifc4.a_in     = '0;
        ifc4.b_in     = '0;
        ifc4.in_valid = 1'b0;

        // Reset for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ifc8.in_ready), 32'(1));
        chk("rst_bit_valid", 32'(ifc8.bit_valid), 32'(0));
        chk("rst_xy", 32'({ifc8.x, ifc8.y}), 32'(0));
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 32'(ifc8.in_ready), 32'(1));
        chk("idle_bit_valid", 32'(ifc8.bit_valid), 32'(0));

        // Single word
        @(posedge clk);
        #1;
        send8(8'h0B, 8'h06);
        repeat (10) @(negedge clk);
        chk("single_run_len", 32'(last_run), 32'(8));
        chk("single_drained", 32'(exp_q.size()), 32'(0));
        chk("single_idle_ready", 32'(ifc8.in_ready), 32'(1));

        // Back-to-back words with in_valid held
        @(posedge clk);
        #1;
        send8(8'hFF, 8'h01);
        send8(8'h80, 8'h80);
        repeat (18) @(negedge clk);
        chk("b2b_run_len", 32'(last_run), 32'(16));
        chk("b2b_drained", 32'(exp_q.size()), 32'(0));

        // in_valid pulse mid-word is ignored
        @(posedge clk);
        #1;
        send8(8'h3C, 8'hC5);
        repeat (2) @(posedge clk);
        #1;
        ifc8.a_in     = 8'hAA;
        ifc8.b_in     = 8'hAA;
        ifc8.in_valid = 1'b1;
        @(negedge clk);
        chk("busy_in_ready", 32'(ifc8.in_ready), 32'(0));
        @(posedge clk);
        #1;
        ifc8.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("pulse_run_len", 32'(last_run), 32'(8));
        chk("pulse_drained", 32'(exp_q.size()), 32'(0));

        // Reset at bit 4 aborts the word
        @(posedge clk);
        #1;
        send8(8'h5A, 8'hA5);
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_bit_valid", 32'(ifc8.bit_valid), 32'(0));
        chk("abort_xy", 32'({ifc8.x, ifc8.y}), 32'(0));
        chk("abort_in_ready", 32'(ifc8.in_ready), 32'(1));
        chk("abort_remaining", 32'(exp_q.size()), 32'(4));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_quiet", 32'(ifc8.bit_valid), 32'(0));

        // W=4 into the serial adder; second word checks the carry clear
        @(posedge clk);
        #1;
        send4(4'hF, 4'h1);
        send4(4'h5, 4'h3);
        repeat (10) @(negedge clk);
        chk("add_count", 32'(res4_q.size()), 32'(2));
        if (res4_q.size() == 2) begin
            chk("add_f_plus_1", 32'(res4_q[0]), 32'(5'h10));
            chk("add_5_plus_3", 32'(res4_q[1]), 32'(5'h08));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
